udp_rx: RTL and testbench

UDP_RX -- requirements
Module: udp_rx

---
 rtl/udp_rx.sv | 158 +++++++++++++++
 tb/tb_udp_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/udp_rx.sv
// UDP segment receiver: parses the 8-byte header from an N-bit MSB-first beat stream and forwards the payload.
// Define UDP_RX_PORT_FILTER_EN to drop segments whose destination port differs from LOCAL_PORT.
module udp_rx #(
  parameter int          N          = 2,
  parameter logic [15:0] LOCAL_PORT = 16'd5000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         axiiv,
  input  logic [N-1:0] axiid,
  output logic         axiov,
  output logic [N-1:0] axiod,
  output logic         axi_last,
  output logic [15:0]  src_port,
  output logic [15:0]  dst_port,
  output logic [15:0]  udp_length,
  output logic [15:0]  udp_checksum,
  output logic         hdr_valid,
  output logic         len_err,
  output logic [2:0]   dbg_state
);

  localparam int HB = 16 / N;
  localparam int CW = $clog2(HB);
  localparam int SH = $clog2(N);

  typedef enum logic [2:0] {
    IDLE, SRC_PORT, DST_PORT, LENGTH, CHECKSUM, PAYLOAD, DROP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] field_cnt_q;
  logic [15:0]   pay_cnt_q;
  logic [63:0]   hdr_q;
  logic          armed_q;
  logic          axiov_q, axi_last_q, hdr_valid_q, len_err_q;
  logic [N-1:0]  axiod_q;
  logic [15:0]   src_q, dst_q, len_q, chk_q;

  logic [63:0]   hdr_d;
  logic [15:0]   len_d, len_m8, pay_bits, pay_beats_d;
  logic          field_done, port_ok;

  // hdr_d already holds the beat being accepted, so decisions at the end of CHECKSUM see the full header
  assign hdr_d       = {hdr_q[63-N:0], axiid};
  assign len_d       = hdr_d[31:16];
  assign len_m8      = len_d - 16'd8;
  assign pay_bits    = len_m8 << 3;
  assign pay_beats_d = pay_bits >> SH;
  assign field_done  = (field_cnt_q == CW'(HB - 1));

`ifdef UDP_RX_PORT_FILTER_EN
  assign port_ok = (hdr_d[47:32] == LOCAL_PORT);
`else
  logic unused_local_port;
  assign unused_local_port = ^LOCAL_PORT;
  assign port_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      field_cnt_q <= '0;
      pay_cnt_q   <= '0;
      hdr_q       <= '0;
      armed_q     <= 1'b0;
      axiov_q     <= 1'b0;
      axiod_q     <= '0;
      axi_last_q  <= 1'b0;
      hdr_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      chk_q       <= '0;
    end else begin
      axiov_q     <= 1'b0;
      axiod_q     <= '0;
      axi_last_q  <= 1'b0;
      hdr_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
      if (!axiiv) begin
        // armed_q stays low after reset until the stream is seen idle once
        state_q     <= IDLE;
        field_cnt_q <= '0;
        pay_cnt_q   <= '0;
        armed_q     <= 1'b1;
        if (state_q inside {SRC_PORT, DST_PORT, LENGTH, CHECKSUM, PAYLOAD})
          len_err_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (armed_q) begin
              hdr_q       <= hdr_d;
              field_cnt_q <= CW'(1);
              state_q     <= SRC_PORT;
            end
          end
          SRC_PORT, DST_PORT, LENGTH: begin
            hdr_q <= hdr_d;
            if (field_done) begin
              field_cnt_q <= '0;
              state_q     <= (state_q == SRC_PORT) ? DST_PORT :
                             (state_q == DST_PORT) ? LENGTH : CHECKSUM;
            end else begin
              field_cnt_q <= field_cnt_q + CW'(1);
            end
          end
          CHECKSUM: begin
            hdr_q <= hdr_d;
            if (field_done) begin
              field_cnt_q <= '0;
              if (!port_ok) begin
                state_q <= DROP;
              end else if (len_d < 16'd8) begin
                len_err_q <= 1'b1;
                state_q   <= DROP;
              end else begin
                hdr_valid_q <= 1'b1;
                src_q       <= hdr_d[63:48];
                dst_q       <= hdr_d[47:32];
                len_q       <= hdr_d[31:16];
                chk_q       <= hdr_d[15:0];
                pay_cnt_q   <= pay_beats_d;
                state_q     <= (pay_beats_d == 16'd0) ? DROP : PAYLOAD;
              end
            end else begin
              field_cnt_q <= field_cnt_q + CW'(1);
            end
          end
          PAYLOAD: begin
            axiov_q   <= 1'b1;
            axiod_q   <= axiid;
            pay_cnt_q <= pay_cnt_q - 16'd1;
            if (pay_cnt_q == 16'd1) begin
              axi_last_q <= 1'b1;
              state_q    <= DROP;
            end
          end
          DROP:    state_q <= DROP;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign axiov        = axiov_q;
  assign axiod        = axiod_q;
  assign axi_last     = axi_last_q;
  assign hdr_valid    = hdr_valid_q;
  assign len_err      = len_err_q;
  assign src_port     = src_q;
  assign dst_port     = dst_q;
  assign udp_length   = len_q;
  assign udp_checksum = chk_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_udp_rx.sv
// Randomized bench for udp_rx: segments are built as byte lists and expectations derived from UDP length rules.
module tb_udp_rx;

  localparam int N = 2;
  localparam int H = 64 / N;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         axiiv = 1'b0;
  logic [N-1:0] axiid = '0;
  logic         axiov, axi_last, hdr_valid, len_err;
  logic [N-1:0] axiod;
  logic [15:0]  src_port, dst_port, udp_length, udp_checksum;
  logic [2:0]   dbg_state;

  always #5 clk = ~clk;

  udp_rx #(.N(N), .LOCAL_PORT(16'd5000)) dut (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
    .axiov(axiov), .axiod(axiod), .axi_last(axi_last),
    .src_port(src_port), .dst_port(dst_port), .udp_length(udp_length),
    .udp_checksum(udp_checksum), .hdr_valid(hdr_valid), .len_err(len_err),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int got_len_err = 0;
  int exp_len_err = 0;
  logic [N:0]  exp_q[$];
  logic [63:0] exp_hdr_q[$];
  logic [63:0] last_hdr = '0;
  logic [7:0]  pay_bytes[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero();
    check("rst_axiov", 64'(axiov), 64'd0);
    check("rst_axiod", 64'(axiod), 64'd0);
    check("rst_last", 64'(axi_last), 64'd0);
    check("rst_hdr_valid", 64'(hdr_valid), 64'd0);
    check("rst_len_err", 64'(len_err), 64'd0);
    check("rst_fields", {src_port, dst_port, udp_length, udp_checksum}, 64'd0);
  endtask

  // Monitor: every output event is matched against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (axiov) begin
        if (exp_q.size() == 0) check("extra_beat", 64'(exp_q.size()), 64'd1);
        else check("beat", 64'({axi_last, axiod}), 64'(exp_q.pop_front()));
      end else if (axi_last) begin
        check("last_wo_valid", 64'(axiov), 64'd1);
      end
      if (hdr_valid) begin
        if (exp_hdr_q.size() == 0) check("extra_hdr", 64'(exp_hdr_q.size()), 64'd1);
        else check("hdr", {src_port, dst_port, udp_length, udp_checksum}, exp_hdr_q.pop_front());
      end
      if (len_err) got_len_err++;
    end
  end

  task automatic fill_rand(input int n);
    pay_bytes.delete();
    for (int i = 0; i < n; i++) pay_bytes.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference: r = beats seen before axiiv falls or reset hits
  task automatic model_seg(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                           input logic [15:0] chk, input logic [N-1:0] bq[$], input int t, input int rst_beat);
    int r, p, k;
    logic [15:0] pbits;
    logic ok;
    r = (rst_beat >= 0) ? rst_beat : t;
    if (r < H) begin
      if (rst_beat < 0) exp_len_err++;
      return;
    end
`ifdef UDP_RX_PORT_FILTER_EN
    ok = (dst == 16'd5000);
`else
    ok = 1'b1;
`endif
    if (!ok) return;
    if (len < 16'd8) begin
      exp_len_err++;
      return;
    end
    exp_hdr_q.push_back({src, dst, len, chk});
    last_hdr = {src, dst, len, chk};
    pbits = (len - 16'd8) * 16'd8;
    p = int'(pbits) / N;
    k = (p < r - H) ? p : r - H;
    for (int j = 0; j < k; j++) exp_q.push_back({(j == p - 1), bq[H + j]});
    if (rst_beat < 0 && (r - H) < p) exp_len_err++;
  endtask

  task automatic run_seg(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                         input logic [15:0] chk, input int npad, input int cut, input int rst_beat,
                         input int gap);
    logic [7:0]   bytes[$];
    logic [N-1:0] bq[$];
    logic [7:0]   sh;
    int t;
    bytes = '{src[15:8], src[7:0], dst[15:8], dst[7:0], len[15:8], len[7:0], chk[15:8], chk[7:0]};
    foreach (pay_bytes[i]) bytes.push_back(pay_bytes[i]);
    for (int i = 0; i < npad; i++) bytes.push_back(8'($urandom_range(0, 255)));
    foreach (bytes[i])
      for (int k = 0; k < 8 / N; k++) begin
        sh = bytes[i] >> (8 - N * (k + 1));
        bq.push_back(sh[N-1:0]);
      end
    t = (cut < 0 || cut > bq.size()) ? bq.size() : cut;
    model_seg(src, dst, len, chk, bq, t, rst_beat);
    for (int i = 0; i < t; i++) begin
      @(posedge clk); #1;
      axiiv = 1'b1;
      axiid = bq[i];
      if (i == rst_beat) begin
        #6 rst = 1'b0;
        #1 check_zero();
        @(posedge clk); #7 rst = 1'b1;
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      axiiv = 1'b0;
      axiid = '0;
    end
    if (gap >= 3) begin
      check("len_err_cnt", 64'(got_len_err), 64'(exp_len_err));
      check("beats_left", 64'(exp_q.size()), 64'd0);
      check("hdr_left", 64'(exp_hdr_q.size()), 64'd0);
    end
  endtask

  initial begin
    logic [15:0] len, dst;
    int npay, mode, cut;
    repeat (3) @(posedge clk);
    #1 check_zero();
    check("rst_state", 64'(dbg_state), 64'd0);
    #6 rst = 1'b1;
    repeat (2) @(posedge clk);

    pay_bytes = '{8'hAB, 8'hCD};
    run_seg(16'h1234, 16'h5678, 16'h000A, 16'h0000, 0, -1, -1, 3);
    run_seg(16'h1234, 16'h5678, 16'h000A, 16'h0000, 6, -1, -1, 3);
    run_seg(16'h1111, 16'h2222, 16'h0004, 16'h0000, 0, -1, -1, 3);
    fill_rand(4);
    run_seg(16'h0A0B, 16'h0C0D, 16'h000C, 16'h5A5A, 0, H + 8, -1, 3);
    fill_rand(0);
    run_seg(16'hBEEF, 16'h1388, 16'h0008, 16'h0001, 4, -1, -1, 3);
    fill_rand(4);
    run_seg(16'h7777, 16'h1388, 16'h000C, 16'h0000, 0, 10, -1, 3);
    fill_rand(2);
    run_seg(16'h4321, 16'h1388, 16'h000A, 16'hFFFF, 0, -1, -1, 3);
    run_seg(16'h4321, 16'h1389, 16'h000A, 16'hFFFF, 0, -1, -1, 3);
    for (int i = 0; i < 3; i++) begin
      fill_rand(i + 1);
      run_seg(16'(16'h100 + i), 16'h1388, 16'(9 + i), 16'h0, 0, -1, -1, (i == 2) ? 3 : 1);
    end
    fill_rand(4);
    run_seg(16'hCAFE, 16'h1388, 16'h000C, 16'h0000, 2, -1, H + 2, 3);
    fill_rand(3);
    run_seg(16'hF00D, 16'h1388, 16'h000B, 16'h1234, 0, -1, -1, 3);

    for (int s = 0; s < 40; s++) begin
      npay = $urandom_range(0, 12);
      fill_rand(npay);
      mode = $urandom_range(0, 7);
      len = 16'(8 + npay);
      if (mode == 0) len = 16'($urandom_range(0, 7));
      if (mode == 1) len = 16'(8 + $urandom_range(0, 16));
      dst = ($urandom_range(0, 1) == 1) ? 16'd5000 : 16'($urandom_range(0, 65535));
      cut = (mode == 2) ? $urandom_range(1, 80) : -1;
      run_seg(16'($urandom_range(0, 65535)), dst, len, 16'($urandom_range(0, 65535)),
              $urandom_range(0, 6), cut, -1, $urandom_range(1, 4));
    end

    repeat (5) @(posedge clk);
    #1;
    check("final_len_err", 64'(got_len_err), 64'(exp_len_err));
    check("final_beats_left", 64'(exp_q.size()), 64'd0);
    check("final_hdr_left", 64'(exp_hdr_q.size()), 64'd0);
    check("final_fields", {src_port, dst_port, udp_length, udp_checksum}, last_hdr);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
